// File: rtl/sha256_job_ctrl.sv
`default_nettype none
// ============================================================================
// sha256_job_ctrl: launches the SHA-256 core for a batch of jobs with an ack
// timeout, queueing each {index, digest} into a first-word-fall-through FIFO.
// Revision: 1.0
// ============================================================================
module sha256_job_ctrl #(
  parameter int JOB_W       = 4,
  parameter int NUM_W       = 8,
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [JOB_W-1:0] job_count,
  input  logic [NUM_W-1:0] num_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             core_en,
  output logic [NUM_W-1:0] core_num,
  input  logic             core_rdy,
  input  logic [255:0]     core_digest,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [255:0]     res_digest,
  output logic [JOB_W-1:0] res_idx,
  output logic [2:0]       status
);

  localparam int c_ptr_w   = $clog2(DEPTH);
  localparam int c_fill_w  = $clog2(DEPTH + 1);
  localparam int c_to_w    = $clog2(ACK_TIMEOUT + 1);
  localparam int c_entry_w = JOB_W + 256;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_PULSE     = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [JOB_W-1:0]    count_q, count_d;
  logic [JOB_W-1:0]    idx_q, idx_d;
  logic [NUM_W-1:0]    num_q, num_d;
  logic [c_to_w-1:0]   to_q, to_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_fill_w-1:0] fill_q, fill_d;
  logic [c_entry_w-1:0] mem_q [DEPTH];
  logic [c_entry_w-1:0] entry_d;

  logic               push;
  logic               pop;
  logic               full;
  logic               last_job;
  logic [c_to_w-1:0]  to_inc;
  logic [c_entry_w-1:0] head;

  assign full     = (fill_q == c_fill_w'(DEPTH));
  assign res_valid = (fill_q != '0);
  assign pop      = res_valid & res_ready;
  assign to_inc   = to_q + 1'b1;
  assign last_job = (({1'b0, idx_q} + 1'b1) == {1'b0, count_q});
  assign entry_d  = {idx_q, core_digest};

  // Job sequencing FSM
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    num_d   = num_q;
    to_d    = to_q;
    err_d   = err_q;
    done_d  = 1'b0;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (job_count != '0) begin
            count_d = job_count;
            num_d   = num_in;
            err_d   = 1'b0;
            idx_d   = '0;
            state_d = S_LAUNCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      // Holding here while full guarantees a capture always has a free slot.
      S_LAUNCH: begin
        if (core_rdy && !full) begin
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        to_d    = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!core_rdy) begin
          state_d = S_WAIT_DONE;
        end else begin
          to_d = to_inc;
          if (to_inc == c_to_w'(ACK_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (core_rdy) begin
          push  = 1'b1;
          idx_d = idx_q + 1'b1;
          if (last_job) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Result FIFO bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      idx_q    <= '0;
      num_q    <= '0;
      to_q     <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      num_q    <= num_d;
      to_q     <= to_d;
      err_q    <= err_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= entry_d;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign res_digest = res_valid ? head[255:0] : '0;
  assign res_idx    = res_valid ? head[c_entry_w-1:256] : '0;

  assign busy     = (state_q != S_IDLE);
  assign core_en  = (state_q == S_PULSE);
  assign done     = done_q;
  assign err      = err_q;
  assign core_num = num_q;
  assign status   = {busy, core_en, core_rdy};

endmodule
`default_nettype wire

// File: tb/tb_sha256_job_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sha256_job_ctrl: directed batches against a transaction-level model of
// the sequencer, a behavioural core and a result scoreboard.
// Revision: 1.0
// ============================================================================
module tb_sha256_job_ctrl;

  localparam int JOB_W       = 4;
  localparam int NUM_W       = 8;
  localparam int DEPTH       = 2;
  localparam int ACK_TIMEOUT = 15;
  localparam int LAT         = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [JOB_W-1:0] job_count = '0;
  logic [NUM_W-1:0] num_in = '0;
  logic             core_rdy = 1'b1;
  logic [255:0]     core_digest = '0;
  logic             res_ready = 1'b0;
  logic             busy, done, err, core_en, res_valid;
  logic [NUM_W-1:0] core_num;
  logic [255:0]     res_digest;
  logic [JOB_W-1:0] res_idx;
  logic [2:0]       status;

  sha256_job_ctrl #(
    .JOB_W(JOB_W), .NUM_W(NUM_W), .DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .job_count(job_count),
    .num_in(num_in), .busy(busy), .done(done), .err(err), .core_en(core_en),
    .core_num(core_num), .core_rdy(core_rdy), .core_digest(core_digest),
    .res_valid(res_valid), .res_ready(res_ready), .res_digest(res_digest),
    .res_idx(res_idx), .status(status)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [255:0] act,
                              input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [255:0] mk_digest(input logic [7:0] n, input logic [7:0] s);
    logic [255:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) d[255-32*i -: 32] = {n, s, 8'(i), 8'hC3};
    return d;
  endfunction

  // Batch-level model state (values expected during the current cycle)
  logic             m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, m_inflight = 1'b0;
  logic [NUM_W-1:0] m_num = '0;
  int               m_total = 0, m_completed = 0, m_launches = 0;
  logic [JOB_W+255:0] m_q[$];
  logic [JOB_W-1:0] dut_pops[$];

  // Behavioural core
  int         c_phase = 0, c_cnt = 0, c_t = 0;
  logic [7:0] c_serial = '0, c_sn = '0;
  logic [NUM_W-1:0] c_num = '0;
  logic       c_mode = 1'b0;  // 1: never acknowledges
  logic       c_hold = 1'b0;  // 1: withholds completion

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_err = 0; m_inflight = 0; m_num = '0;
      m_total = 0; m_completed = 0; m_q.delete();
      c_phase = 0; c_cnt = 0; c_t = 0; c_serial = '0; core_rdy = 1'b1;
    end else begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("core_num", core_num, m_num);
      chk("res_valid", res_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("res_idx", res_idx, m_q[0][JOB_W+255:256]);
        chk("res_digest", res_digest, m_q[0][255:0]);
      end
      chk("status", status, {m_busy, core_en, core_rdy});
      if (core_en) chk("launch_allowed", m_busy && !m_inflight && (m_q.size() < DEPTH), 1'b1);
      if (res_valid && res_ready) dut_pops.push_back(res_idx);

      // Advance to next-cycle expectations
      m_done = 0;
      if (res_ready && m_q.size() != 0) void'(m_q.pop_front());
      if (start && !m_busy) begin
        if (job_count == 0) m_done = 1;
        else begin
          m_busy = 1; m_err = 0; m_total = int'(job_count); m_num = num_in; m_completed = 0;
        end
      end
      case (c_phase)
        0: if (core_en) begin
          c_num = core_num; c_sn = c_serial; c_serial++;
          m_inflight = 1; m_launches++;
          if (c_mode) begin c_phase = 3; c_t = 0; end
          else c_phase = 1;
        end
        1: begin core_rdy = 1'b0; c_cnt = LAT; c_phase = 2; end
        2: begin
          if (c_cnt > 0) c_cnt--;
          if (c_cnt == 0 && !c_hold) begin
            core_rdy = 1'b1;
            core_digest = mk_digest(c_num, c_sn);
            c_phase = 0;
            m_q.push_back({JOB_W'(m_completed), core_digest});
            m_completed++;
            m_inflight = 0;
            if (m_completed == m_total) begin m_busy = 0; m_done = 1; end
          end
        end
        3: begin
          c_t++;
          if (c_t == ACK_TIMEOUT) begin m_err = 1; m_busy = 0; m_inflight = 0; c_phase = 0; end
        end
        default: c_phase = 0;
      endcase
    end
  end

  task automatic do_start(input logic [JOB_W-1:0] cnt, input logic [NUM_W-1:0] n);
    @(posedge clk); #1;
    start = 1'b1; job_count = cnt; num_in = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    int t = 0;
    while (done !== 1'b1 && t < max) begin @(negedge clk); t++; end
    chk(name, done, 1'b1);
  endtask

  task automatic run_single(input string tag);
    int t;
    int base;
    base = m_launches;
    do_start(1, 8'd32);
    @(negedge clk);
    chk({tag, "_busy_c1"}, busy, 1'b1);
    chk({tag, "_en_c1"}, core_en, 1'b0);
    @(negedge clk);
    chk({tag, "_en_c2"}, core_en, 1'b1);
    chk({tag, "_num"}, core_num, 8'd32);
    t = 2;
    while (!res_valid && t < 300) begin @(negedge clk); t++; end
    chk({tag, "_valid_cycle"}, t, 68);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_idx"}, res_idx, 0);
    chk({tag, "_word_a"}, res_digest[255:224], 32'h200000C3);
    chk({tag, "_word_h"}, res_digest[31:0], 32'h200007C3);
    @(posedge clk); #1;
    chk({tag, "_launches"}, m_launches - base, 1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_drained"}, res_valid, 1'b0);
  endtask

  initial begin
    int base, pbase, t;
    logic saw_done;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_en", core_en, 1'b0);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_num", core_num, 0);
    chk("rst_digest", res_digest, 0);
    chk("rst_idx", res_idx, 0);
    chk("rst_status", status, 3'b001);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single job with literal timing
    run_single("s1");

    // Back-pressure: FIFO of two holds the third launch
    base = m_launches;
    do_start(3, 8'd7);
    repeat (300) @(negedge clk);
    chk("bp_busy", busy, 1'b1);
    chk("bp_valid", res_valid, 1'b1);
    chk("bp_head", res_idx, 0);
    chk("bp_launches_held", m_launches - base, 2);
    pbase = dut_pops.size();
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_done("bp_done", 600);
    repeat (3) @(negedge clk);
    chk("bp_launches", m_launches - base, 3);
    chk("bp_pops", dut_pops.size() - pbase, 3);
    if (dut_pops.size() - pbase == 3) begin
      chk("bp_pop0", dut_pops[pbase], 0);
      chk("bp_pop1", dut_pops[pbase+1], 1);
      chk("bp_pop2", dut_pops[pbase+2], 2);
    end

    // Start while busy is ignored; zero-count start only pulses done
    base = m_launches;
    do_start(2, 8'd9);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    start = 1'b1; job_count = 4'd5; num_in = 8'd99;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("rs_done", 400);
    chk("rs_launches", m_launches - base, 2);
    chk("rs_num", core_num, 8'd9);
    base = m_launches;
    do_start(0, 8'd50);
    @(negedge clk);
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    chk("zero_launches", m_launches - base, 0);

    // Ack timeout
    c_mode = 1'b1;
    do_start(1, 8'd3);
    saw_done = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (i == 17) begin chk("to_err_c17", err, 1'b0); chk("to_busy_c17", busy, 1'b1); end
      if (i == 18) begin chk("to_err_c18", err, 1'b1); chk("to_busy_c18", busy, 1'b0); end
    end
    chk("to_no_done", saw_done, 1'b0);
    chk("to_fifo", res_valid, 1'b0);
    chk("to_err_sticky", err, 1'b1);
    @(posedge clk); #1;
    c_mode = 1'b0;
    do_start(1, 8'd4);
    @(negedge clk);
    chk("to_err_cleared", err, 1'b0);
    wait_done("to_rerun_done", 200);
    repeat (3) @(negedge clk);

    // Push and pop in the same cycle at count 1
    @(posedge clk); #1;
    res_ready = 1'b0;
    do_start(2, 8'd5);
    t = 0;
    while (m_completed < 1 && t < 300) begin @(posedge clk); #1; t++; end
    chk("pp_first", m_completed, 1);
    c_hold = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("pp_head0", res_idx, 0);
    chk("pp_valid0", res_valid, 1'b1);
    chk("pp_busy", busy, 1'b1);
    res_ready = 1'b1;
    c_hold = 1'b0;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("pp_valid1", res_valid, 1'b1);
    chk("pp_head1", res_idx, 1);
    chk("pp_done", done, 1'b1);

    // Reset during WAIT_DONE, with one result still queued
    do_start(1, 8'd32);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_en", core_en, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_valid", res_valid, 1'b0);
    chk("ar_err", err, 1'b0);
    chk("ar_done", done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_single("s6");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
